// File: rtl/hs_channel_arbiter_if.sv
// Handshake bundle between NUM_CH producers, the channel arbiter and one consumer.
// The arbiter uses the slave modport; the producer/consumer side uses master.
interface hs_channel_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned NUM_CH     = 4
);
   localparam int unsigned ChW = $clog2(NUM_CH);

   logic [NUM_CH-1:0]            in_valid;
   logic [NUM_CH*DATA_WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]            in_ready;
   logic                         out_valid;
   logic                         out_ready;
   logic [DATA_WIDTH-1:0]        out_data;
   logic [ChW-1:0]               out_ch;
   logic [NUM_CH-1:0]            drop_err;
   logic                         drop_clr;

   modport master (
      output in_valid, in_data, out_ready, drop_clr,
      input  in_ready, out_valid, out_data, out_ch, drop_err
   );

   modport slave (
      input  in_valid, in_data, out_ready, drop_clr,
      output in_ready, out_valid, out_data, out_ch, drop_err
   );
endinterface

// File: rtl/hs_channel_arbiter.sv
// Per-channel circular FIFOs drained round-robin into one registered valid/ready output
// tagged with its source channel; writes to a full channel are dropped and flagged.
module hs_channel_arbiter #(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned DEPTH      = 2
) (
   input logic                  clk,
   input logic                  resetb,
   hs_channel_arbiter_if.slave  bus
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;
   localparam int unsigned ChW  = $clog2(NUM_CH);
   localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [NUM_CH][DEPTH];
   logic [PtrW-1:0]       wr_ptr_q [NUM_CH];
   logic [PtrW-1:0]       wr_ptr_d [NUM_CH];
   logic [PtrW-1:0]       rd_ptr_q [NUM_CH];
   logic [PtrW-1:0]       rd_ptr_d [NUM_CH];
   logic [CntW-1:0]       cnt_q [NUM_CH];
   logic [CntW-1:0]       cnt_d [NUM_CH];

   logic [NUM_CH-1:0]     ready, nonempty, push, pop;
   logic [NUM_CH-1:0]     drop_err_q, drop_err_d;
   logic [ChW-1:0]        last_q, last_d, grant, out_ch_q, out_ch_d;
   logic                  grant_vld, load;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   int unsigned           cand;

   // Ready depends only on the registered count, never on this cycle's pop.
   always_comb begin
      ready    = '0;
      nonempty = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         ready[c]    = cnt_q[c] < DepthCnt;
         nonempty[c] = cnt_q[c] != '0;
      end
   end

   assign push = bus.in_valid & ready;
   assign load = ~out_valid_q | bus.out_ready;

   // Round-robin search starting just above the last granted channel.
   always_comb begin
      grant_vld = 1'b0;
      grant     = last_q;
      cand      = 0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         cand = 32'(last_q) + i;
         if (cand >= NUM_CH) cand = cand - NUM_CH;
         if (!grant_vld && nonempty[ChW'(cand)]) begin
            grant_vld = 1'b1;
            grant     = ChW'(cand);
         end
      end
   end

   always_comb begin
      pop = '0;
      if (load && grant_vld) pop[grant] = 1'b1;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         wr_ptr_d[c] = wr_ptr_q[c] + PtrW'(push[c]);
         rd_ptr_d[c] = rd_ptr_q[c] + PtrW'(pop[c]);
         cnt_d[c]    = cnt_q[c] + CntW'(push[c]) - CntW'(pop[c]);
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      last_d      = last_q;
      if (load) begin
         out_valid_d = grant_vld;
         if (grant_vld) begin
            out_data_d = mem_q[grant][rd_ptr_q[grant]];
            out_ch_d   = grant;
            last_d     = grant;
         end
      end
      // A new drop wins over a same-cycle clear.
      drop_err_d = (bus.drop_clr ? '0 : drop_err_q) | (bus.in_valid & ~ready);
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
            cnt_q[c]    <= '0;
         end
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         last_q      <= ChW'(NUM_CH - 1);
         drop_err_q  <= '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            wr_ptr_q[c] <= wr_ptr_d[c];
            rd_ptr_q[c] <= rd_ptr_d[c];
            cnt_q[c]    <= cnt_d[c];
         end
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         last_q      <= last_d;
         drop_err_q  <= drop_err_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (push[c]) mem_q[c][wr_ptr_q[c]] <= bus.in_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.drop_err  = drop_err_q;
endmodule

// File: tb/tb_hs_channel_arbiter.sv
// Directed and randomized bench for hs_channel_arbiter against a queue-based reference model.
module tb_hs_channel_arbiter;
   localparam int unsigned DW  = 64;
   localparam int unsigned NC  = 4;
   localparam int unsigned DEP = 2;

   logic clk = 1'b0;
   logic resetb;
   always #5 clk = ~clk;

   hs_channel_arbiter_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus ();

   hs_channel_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(DEP)) dut (
      .clk    (clk),
      .resetb (resetb),
      .bus    (bus)
   );

   // Reference model: one queue per channel plus the output register contents.
   logic [DW-1:0] mq [NC][$];
   logic          m_valid;
   logic [DW-1:0] m_data;
   int            m_ch;
   int            m_last;
   logic [NC-1:0] m_drop;

   int checks;
   int errors;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NC; c++) mq[c].delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_last  = NC - 1;
      m_drop  = '0;
   endtask

   task automatic model_edge(input logic [NC-1:0] v, input logic [NC*DW-1:0] d, input logic r,
                             input logic clr);
      logic [NC-1:0] rdy;
      logic [NC-1:0] drops;
      bit found;
      int c;
      drops = '0;
      for (int k = 0; k < NC; k++) rdy[k] = mq[k].size() < DEP;
      if (!m_valid || r) begin
         found = 0;
         for (int k = 1; k <= NC; k++) begin
            c = (m_last + k) % NC;
            if (!found && mq[c].size() > 0) begin
               found  = 1;
               m_data = mq[c].pop_front();
               m_ch   = c;
               m_last = c;
            end
         end
         m_valid = found;
      end
      for (int k = 0; k < NC; k++) begin
         if (v[k]) begin
            if (rdy[k]) mq[k].push_back(d[k*DW +: DW]);
            else drops[k] = 1'b1;
         end
      end
      m_drop = (clr ? '0 : m_drop) | drops;
   endtask

   task automatic compare_all(input string tag);
      logic [NC-1:0] er;
      for (int k = 0; k < NC; k++) er[k] = mq[k].size() < DEP;
      check({tag, "/valid"}, DW'(bus.out_valid), DW'(m_valid));
      check({tag, "/data"}, bus.out_data, m_data);
      check({tag, "/ch"}, DW'(bus.out_ch), DW'(m_ch));
      check({tag, "/ready"}, DW'(bus.in_ready), DW'(er));
      check({tag, "/drop"}, DW'(bus.drop_err), DW'(m_drop));
   endtask

   // Drive at the falling edge, advance the model, compare after the next rising edge.
   task automatic step(input logic [NC-1:0] v, input logic [NC*DW-1:0] d, input logic r,
                       input logic clr, input string tag);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
      bus.drop_clr  = clr;
      model_edge(v, d, r, clr);
      @(posedge clk);
      @(negedge clk);
      compare_all(tag);
   endtask

   task automatic do_reset();
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      bus.drop_clr  = 1'b0;
      resetb = 1'b0;
      model_reset();
      #1;
      compare_all("reset");
      check("reset/ready_ones", DW'(bus.in_ready), DW'(4'b1111));
      @(negedge clk);
      resetb = 1'b1;
   endtask

   function automatic logic [NC*DW-1:0] rand_data();
      logic [NC*DW-1:0] d;
      for (int k = 0; k < NC; k++) d[k*DW +: DW] = {$urandom, $urandom};
      return d;
   endfunction

   logic [NC*DW-1:0] d;
   logic [DW-1:0]    w [4];

   initial begin
      checks = 0;
      errors = 0;
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      bus.drop_clr  = 1'b0;
      resetb = 1'b0;
      model_reset();
      #2;
      compare_all("init");
      check("init/ready_ones", DW'(bus.in_ready), DW'(4'b1111));
      check("init/drop_zero", DW'(bus.drop_err), '0);
      @(negedge clk);
      resetb = 1'b1;

      // Single write on ch2: two-edge latency.
      d = '0;
      d[2*DW +: DW] = 64'hA5;
      step(4'b0100, d, 1'b1, 1'b0, "lat1");
      check("lat1/not_yet", DW'(bus.out_valid), '0);
      step('0, '0, 1'b1, 1'b0, "lat2");
      check("lat2/valid", DW'(bus.out_valid), DW'(1));
      check("lat2/data", bus.out_data, 64'hA5);
      check("lat2/ch", DW'(bus.out_ch), DW'(2));

      // All four channels at once: fair order 0..3 from reset.
      do_reset();
      step(4'b1111, rand_data(), 1'b1, 1'b0, "all_w");
      for (int i = 0; i < NC; i++) begin
         step('0, '0, 1'b1, 1'b0, "all_d");
         check("all/order", DW'(bus.out_ch), DW'(i));
      end
      step('0, '0, 1'b1, 1'b0, "all_e");
      check("all/empty", DW'(bus.out_valid), '0);

      // Stalled output, ch1 fills, fourth write dropped.
      for (int i = 0; i < 4; i++) w[i] = {$urandom, $urandom};
      for (int i = 0; i < 4; i++) begin
         d = '0;
         d[1*DW +: DW] = w[i];
         step(4'b0010, d, 1'b0, 1'b0, "fill");
         if (i == 2) check("fill/full", DW'(bus.in_ready[1]), '0);
      end
      check("fill/drop", DW'(bus.drop_err), DW'(4'b0010));
      for (int i = 0; i < 5; i++) begin
         step('0, '0, 1'b0, 1'b0, "hold");
         check("hold/data", bus.out_data, w[0]);
         check("hold/ch", DW'(bus.out_ch), DW'(1));
      end
      d = '0;
      d[1*DW +: DW] = {$urandom, $urandom};
      step(4'b0010, d, 1'b0, 1'b1, "dropclr");
      check("dropclr/kept", DW'(bus.drop_err), DW'(4'b0010));
      step('0, '0, 1'b0, 1'b1, "clr");
      check("clr/cleared", DW'(bus.drop_err), '0);
      step('0, '0, 1'b1, 1'b0, "drain1");
      check("drain1/data", bus.out_data, w[1]);
      step('0, '0, 1'b1, 1'b0, "drain2");
      check("drain2/data", bus.out_data, w[2]);
      step('0, '0, 1'b1, 1'b0, "drain3");
      check("drain3/empty", DW'(bus.out_valid), '0);

      // Reset while three channels hold data.
      step(4'b0111, rand_data(), 1'b0, 1'b0, "pre1");
      step(4'b0111, rand_data(), 1'b0, 1'b0, "pre2");
      #2;
      do_reset();
      check("midrst/valid", DW'(bus.out_valid), '0);
      for (int i = 0; i < 3; i++) begin
         step('0, '0, 1'b1, 1'b0, "post");
         check("post/no_stale", DW'(bus.out_valid), '0);
      end

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         step(4'($urandom), rand_data(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
              "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
